// File: rtl/and_seq_pkg.sv
// Shared types and constants for the AND-gate test sequencer.
package and_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int NUM_VECTORS = 4;
    localparam int ERR_W       = 4;
    localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

    // Mismatch counter increment that sticks at ERR_MAX.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/and_vector_seq_if.sv
// Signal bundle between the sequencer (master) and the stage under test plus its controller (slave).
interface and_vector_seq_if;

    logic                         start;
    logic                         c;
    logic                         a;
    logic                         b;
    logic                         busy;
    logic                         done;
    logic                         pass;
    logic [and_seq_pkg::ERR_W-1:0] err_count;
    logic [1:0]                   vec_idx;

    modport master (
        input  start, c,
        output a, b, busy, done, pass, err_count, vec_idx
    );

    modport slave (
        output start, c,
        input  a, b, busy, done, pass, err_count, vec_idx
    );

endinterface

// File: rtl/and_vector_seq_hold_timer.sv
// Dwell timer: load to HOLD_CYCLES, count down while enabled, flag the last dwell cycle.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = 8'(HOLD_CYCLES);
        end else if (en_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of 1 marks the final cycle of the dwell, so DRIVE lasts exactly HOLD_CYCLES.
    assign expired_o = (cnt_q == 8'd1);

endmodule

// File: rtl/and_vector_seq.sv
// Drives the four 2-bit vectors into an AND stage for PASSES sweeps and counts wrong results.
module and_vector_seq
    import and_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned PASSES      = 2
) (
    input  logic             clk,
    input  logic             rst,
    and_vector_seq_if.master bus
);

    localparam logic [1:0] LAST_VEC  = 2'(NUM_VECTORS - 1);
    localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic [1:0]       next_idx;
    logic             timer_load;
    logic             timer_en;
    logic             timer_exp;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (timer_load),
        .en_i      (timer_en),
        .expired_o (timer_exp)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pcnt_d     = pcnt_q;
        err_d      = err_q;
        pass_d     = pass_q;
        a_d        = a_q;
        b_d        = b_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        next_idx   = vec_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (bus.start) begin
                    state_d    = ST_DRIVE;
                    vec_d      = 2'd0;
                    pcnt_d     = 8'd0;
                    err_d      = '0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end

            ST_DRIVE: begin
                timer_en = 1'b1;
                if (timer_exp) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (bus.c != (a_q & b_q)) begin
                    err_d = sat_inc(err_q);
                end
                if (vec_q != LAST_VEC) begin
                    state_d    = ST_DRIVE;
                    vec_d      = next_idx;
                    a_d        = next_idx[1];
                    b_d        = next_idx[0];
                    timer_load = 1'b1;
                end else if (pcnt_q < LAST_PASS) begin
                    state_d    = ST_DRIVE;
                    vec_d      = 2'd0;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    pcnt_d     = pcnt_q + 8'd1;
                    timer_load = 1'b1;
                end else begin
                    // Verdict uses err_d so a mismatch in this last sample is counted.
                    state_d = ST_DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    pass_d  = (err_d == '0);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'd0;
            pcnt_q  <= 8'd0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.vec_idx   = vec_q;

endmodule

// File: tb/tb_and_vector_seq.sv
// Bench for and_vector_seq: a default instance (HOLD 4, PASSES 2) and a short-dwell, many-pass instance.
module tb_and_vector_seq;

    localparam int H0 = 4;
    localparam int P0 = 2;
    localparam int H1 = 1;
    localparam int P1 = 8;

    logic       clk;
    logic       rst_s   [2];
    logic       start_s [2];
    logic [3:0] fault_s [2];

    logic       a_w    [2];
    logic       b_w    [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       pass_w [2];
    logic [3:0] err_w  [2];
    logic [1:0] vec_w  [2];

    int checks   = 0;
    int failures = 0;

    and_vector_seq_if if0 ();
    and_vector_seq_if if1 ();

    and_vector_seq #(.HOLD_CYCLES(H0), .PASSES(P0)) u0 (
        .clk (clk),
        .rst (rst_s[0]),
        .bus (if0.master)
    );

    and_vector_seq #(.HOLD_CYCLES(H1), .PASSES(P1)) u1 (
        .clk (clk),
        .rst (rst_s[1]),
        .bus (if1.master)
    );

    // Downstream AND stage with a per-vector fault mask indexed by {a,b}.
    assign if0.start = start_s[0];
    assign if1.start = start_s[1];
    assign if0.c = (if0.a & if0.b) ^ fault_s[0][{if0.a, if0.b}];
    assign if1.c = (if1.a & if1.b) ^ fault_s[1][{if1.a, if1.b}];

    assign a_w[0] = if0.a;          assign a_w[1] = if1.a;
    assign b_w[0] = if0.b;          assign b_w[1] = if1.b;
    assign busy_w[0] = if0.busy;    assign busy_w[1] = if1.busy;
    assign done_w[0] = if0.done;    assign done_w[1] = if1.done;
    assign pass_w[0] = if0.pass;    assign pass_w[1] = if1.pass;
    assign err_w[0] = if0.err_count; assign err_w[1] = if1.err_count;
    assign vec_w[0] = if0.vec_idx;  assign vec_w[1] = if1.vec_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         u;
        logic [3:0] fault;
        int         exp_err;
        logic       exp_pass;
        int         restart_cyc;
        int         late_cyc;
        logic [3:0] late_fault;
        bit         start_in_done;
        string      name;
    } run_t;

    run_t tbl [10];

    function automatic int hold_of(input int u);
        return (u == 0) ? H0 : H1;
    endfunction

    function automatic int passes_of(input int u);
        return (u == 0) ? P0 : P1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full run; cycle 0 is the cycle in which start is sampled.
    task automatic do_run(input run_t r);
        int   h;
        int   p;
        int   len;
        int   cyc;
        int   j;
        int   busy_bad;
        int   seq_bad;
        logic pass_at_done;
        logic [3:0] err_at_done;
        h = hold_of(r.u);
        p = passes_of(r.u);
        len = 4 * p * (h + 1) + 1;
        busy_bad = 0;
        seq_bad = 0;
        fault_s[r.u] = r.fault;
        @(negedge clk);
        start_s[r.u] = 1'b1;
        @(negedge clk);
        start_s[r.u] = 1'b0;
        cyc = 1;
        chk({r.name, "_cleared_err"}, int'(err_w[r.u]), 0);
        chk({r.name, "_cleared_pass"}, int'(pass_w[r.u]), 0);
        while (!done_w[r.u] && cyc <= len + 5) begin
            if (busy_w[r.u] !== 1'b1) busy_bad++;
            if (cyc < len) begin
                j = ((cyc - 1) / (h + 1)) % 4;
                if (int'(vec_w[r.u]) != j || a_w[r.u] !== j[1] || b_w[r.u] !== j[0]) seq_bad++;
            end
            start_s[r.u] = (cyc == r.restart_cyc);
            if (cyc == r.late_cyc) fault_s[r.u] = r.late_fault;
            @(negedge clk);
            cyc++;
        end
        start_s[r.u] = 1'b0;
        chk({r.name, "_busy_during_run"}, busy_bad, 0);
        chk({r.name, "_vector_sequence"}, seq_bad, 0);
        chk({r.name, "_done_cycle"}, cyc, len);
        chk({r.name, "_busy_in_done"}, int'(busy_w[r.u]), 1);
        chk({r.name, "_ab_in_done"}, int'({a_w[r.u], b_w[r.u]}), 0);
        chk({r.name, "_err_count"}, int'(err_w[r.u]), r.exp_err);
        chk({r.name, "_pass"}, int'(pass_w[r.u]), int'(r.exp_pass));
        pass_at_done = pass_w[r.u];
        err_at_done = err_w[r.u];
        if (r.start_in_done) start_s[r.u] = 1'b1;
        @(negedge clk);
        start_s[r.u] = 1'b0;
        chk({r.name, "_done_one_cycle"}, int'(done_w[r.u]), 0);
        chk({r.name, "_idle_after"}, int'(busy_w[r.u]), 0);
        chk({r.name, "_pass_held"}, int'(pass_w[r.u]), int'(pass_at_done));
        chk({r.name, "_err_held"}, int'(err_w[r.u]), int'(err_at_done));
        chk({r.name, "_ab_idle"}, int'({a_w[r.u], b_w[r.u]}), 0);
        $display("run %s inst=%0d fault=%b err=%0d pass=%0d done_cycle=%0d", r.name, r.u, r.fault,
                 err_at_done, pass_at_done, cyc);
    endtask

    task automatic reset_abort();
        int done_seen;
        fault_s[0] = 4'b0111;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (11) @(negedge clk);
        // Now in cycle 12: vectors 00 and 01 have both mismatched under stuck-high.
        chk("abort_err_before", int'(err_w[0]), 2);
        rst_s[0] = 1'b1;
        @(negedge clk);
        rst_s[0] = 1'b0;
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_ab", int'({a_w[0], b_w[0]}), 0);
        chk("abort_err", int'(err_w[0]), 0);
        chk("abort_vec", int'(vec_w[0]), 0);
        done_seen = 0;
        repeat (50) begin
            if (done_w[0] || busy_w[0]) done_seen++;
            @(negedge clk);
        end
        chk("abort_no_done", done_seen, 0);
        $display("run reset_abort inst=0 done_or_busy_after=%0d", done_seen);
    endtask

    initial begin
        tbl[0] = '{0, 4'b0000,  0, 1'b1, -1, -1, 4'b0000, 1'b0, "correct"};
        tbl[1] = '{0, 4'b1000,  2, 1'b0, -1, -1, 4'b0000, 1'b0, "stuck_low"};
        tbl[2] = '{0, 4'b0111,  6, 1'b0, -1, -1, 4'b0000, 1'b0, "stuck_high"};
        tbl[3] = '{0, 4'b0000,  0, 1'b1, 20, -1, 4'b0000, 1'b0, "start_busy"};
        tbl[4] = '{0, 4'b0000,  0, 1'b1, -1, -1, 4'b0000, 1'b1, "start_in_done"};
        tbl[5] = '{0, 4'b0000,  1, 1'b0, -1, 36, 4'b1000, 1'b0, "last_sample"};
        tbl[6] = '{1, 4'b1111, 15, 1'b0, -1, -1, 4'b0000, 1'b0, "saturate"};
        tbl[7] = '{1, 4'b0001,  8, 1'b0, -1, -1, 4'b0000, 1'b0, "vec00_only"};
        tbl[8] = '{1, 4'b0011, 15, 1'b0, -1, -1, 4'b0000, 1'b0, "sat_boundary"};
        tbl[9] = '{0, 4'b0010,  2, 1'b0, -1, -1, 4'b0000, 1'b0, "vec01_only"};

        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1;
            start_s[i] = 1'b1;
            fault_s[i] = 4'b0000;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_busy%0d", i), int'(busy_w[i]), 0);
            chk($sformatf("reset_done%0d", i), int'(done_w[i]), 0);
            chk($sformatf("reset_pass%0d", i), int'(pass_w[i]), 0);
            chk($sformatf("reset_err%0d", i), int'(err_w[i]), 0);
            chk($sformatf("reset_vec%0d", i), int'(vec_w[i]), 0);
            chk($sformatf("reset_ab%0d", i), int'({a_w[i], b_w[i]}), 0);
            rst_s[i] = 1'b0;
            start_s[i] = 1'b0;
        end
        $display("reset checked on both instances");

        for (int i = 0; i < 10; i++) begin
            do_run(tbl[i]);
        end

        reset_abort();

        // Random fault masks; expected count is mismatching vectors times passes, capped at 15.
        for (int k = 0; k < 10; k++) begin
            run_t r;
            int   p;
            int   len;
            int   e;
            r.u = int'($urandom_range(0, 1));
            r.fault = 4'($urandom_range(0, 15));
            p = passes_of(r.u);
            len = 4 * p * (hold_of(r.u) + 1) + 1;
            e = p * $countones(r.fault);
            r.exp_err = (e > 15) ? 15 : e;
            r.exp_pass = (e == 0);
            r.restart_cyc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, len - 2)) : -1;
            r.late_cyc = -1;
            r.late_fault = 4'b0000;
            r.start_in_done = 1'($urandom_range(0, 1));
            r.name = $sformatf("rand%0d", k);
            do_run(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
